doc_uart_sender: RTL and testbench
==================================

# doc_uart_sender

Streams the text document out over a UART TX line when the user presses the send button. Sits directly downstream of the document RAM and text editor, on the document's read port (`read_enable` / `read_out_addr` / `spo`). Walks the visible 15×20 character grid row by row and transmits each byte as 8N1. Appends CR LF after every row, then pulses `done`, which drives the text editor's `clear_data`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 2.
- `ROWS`, default 15: document rows sent (row index 0..ROWS-1, ≤ 16).
- `COLS`, default 20: columns sent per row (col index 0..COLS-1, ≤ 32).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `send_data`, in, 1: send request, already debounced level; the block edge-detects it internally.
- `read_enable`, out, 1: high while the block owns the document read port.
- `read_addr`, out, 9: document address `{row[3:0], col[4:0]}`.
- `read_data`, in, 8: document byte at `read_addr` (combinational RAM read).
- `tx`, out, 1: UART serial output, idle high.
- `busy`, out, 1: high from the request until `done`.
- `done`, out, 1: one-cycle pulse after the final stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `read_enable`=0, `read_addr`=0; all counters 0; FSM in IDLE. Reset asserted mid-frame aborts immediately, and no `done` is issued.
- Rising-edge detection: register `send_q <= send_data`; a start is `send_data & ~send_q`. Starts seen while `busy` is high are ignored. A held button does not retrigger.
- FSM states:
  - **IDLE**: on a start, go to FETCH with row=0, col=0, `busy`=1.
  - **FETCH**: `read_enable`=1 and `read_addr`={row,col} for exactly one cycle. At the clock edge, latch `read_data` into the shift register and go to START. A byte of 8'h00 is replaced by 8'h20 (space); all other bytes are sent verbatim.
  - **START**: `tx`=0 for CLKS_PER_BIT cycles.
  - **DATA**: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit counter tracks the bit index.
  - **STOP**: `tx`=1 for CLKS_PER_BIT cycles, then go to NEXT.
  - **NEXT** (1 cycle), with a 2-bit phase: 0 = char, 1 = CR, 2 = LF.
    - After a char with col < COLS-1: col++ and go to FETCH.
    - After a char with col = COLS-1: load 8'h0D, phase=1, go to START.
    - After CR: load 8'h0A, phase=2, go to START.
    - After LF with row < ROWS-1: row++, col=0, phase=0, go to FETCH.
    - After LF with row = ROWS-1: go to DONE.
  - **DONE** (1 cycle): `done`=1, `busy` falls, return to IDLE.
- CR and LF bytes never touch the document; `read_enable` stays 0 for them.
- `read_enable` is 0 in every state except FETCH. `read_addr` holds its last value otherwise.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It reloads to 0 on entry to START, on each DATA bit boundary, and on entry to STOP.
- Total bytes per transfer = ROWS×(COLS+2); 330 at the defaults.

## Timing
- Start edge sampled at cycle k: FETCH at k+1, `tx` falls at k+2.
- Each byte occupies 10×CLKS_PER_BIT cycles on the line.
- Inter-byte gap: 2 cycles before a char (NEXT + FETCH) and 1 cycle before CR or LF (NEXT). `tx` stays 1 during gaps.
- `done` asserts 1 cycle after the final LF stop bit ends (NEXT then DONE).
- `busy`=1 from k+1 through the cycle before DONE's successor, and is low again when `done` is low.
- `send_data` rising in the same cycle as DONE is ignored.

## Test plan
- Reset idle: assert `rst` mid-simulation. Required: `tx`=1, `busy`=0, `read_enable`=0 asynchronously, before the next clock edge.
- Basic frame, with CLKS_PER_BIT=4, ROWS=1, COLS=1, document[0]=8'h41:
  - Required line output: 0,1,0,0,0,0,0,1,0,1 (4 cycles each), then 0x0D, then 0x0A.
  - Required handshake: `done` pulses once; `read_enable` is high for exactly 1 cycle with `read_addr`=0.
- Full scan, with ROWS=2, COLS=3, distinct bytes per cell:
  - Required decoded stream: c00 c01 c02 0D 0A c10 c11 c12 0D 0A.
  - Required addresses in order: 0x000, 0x001, 0x002, 0x020, 0x021, 0x022.
- Null mapping: a cell holding 8'h00 is received as 8'h20; a cell holding 8'h7F is received as 8'h7F.
- Retrigger: toggle `send_data` mid-transfer and hold it high past `done`. Required: exactly one transfer and one `done` pulse; a fresh rising edge afterwards starts a second transfer.
- Reset mid-DATA: assert `rst` during bit 3. Required: `tx`=1 immediately, no `done`; the next send restarts at address 0.

Source files
------------

// File: rtl/doc_uart_sender.sv
// doc_uart_sender
// Streams the visible document grid out over a UART TX line (8N1) when the
// send button is pressed. Cells are read row by row through the document
// read port; every row is followed by CR LF. A one-cycle done pulse marks
// the end of the transfer and is used to clear the editor.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   send_data    debounced send button level (rising edge starts a transfer)
//   read_enable  high for the single cycle the block reads the document
//   read_addr    document address {row[3:0], col[4:0]}
//   read_data    document byte at read_addr (combinational RAM read)
//   tx           UART serial output, idle high
//   busy         high from the accepted request through the done cycle
//   done         one-cycle pulse after the final LF stop bit
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a rising edge on send_data
// FETCH | read the document cell {row,col}, latch it into the shift reg
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles
// NEXT  | choose next byte: next cell, CR, LF, next row, or finish
// DONE  | pulse done for one cycle, then back to IDLE

module doc_uart_sender #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ROWS         = 15,
   parameter int COLS         = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_data,
   output logic       read_enable,
   output logic [8:0] read_addr,
   input  logic [7:0] read_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
   localparam logic [3:0]    ROW_LAST  = 4'(ROWS - 1);

   localparam logic [1:0] PH_CHAR = 2'd0;
   localparam logic [1:0] PH_CR   = 2'd1;
   localparam logic [1:0] PH_LF   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            send_q;
   logic            start;
   logic [3:0]      row;
   logic [4:0]      col;
   logic [1:0]      phase;
   logic [7:0]      shreg;
   logic [2:0]      bit_idx;
   logic [BW-1:0]   baud_cnt;
   logic            baud_end;

   assign start    = send_data & ~send_q;
   assign baud_end = (baud_cnt == BAUD_LAST);

   // row/col only move on the way into FETCH, so the address naturally
   // holds its last value in every other state.
   assign read_addr = {row, col};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         send_q   <= 1'b0;
         row      <= '0;
         col      <= '0;
         phase    <= PH_CHAR;
         shreg    <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
      end else begin
         state  <= state_nxt;
         send_q <= send_data;
         case (state)
            S_IDLE: begin
               if (start) begin
                  row   <= '0;
                  col   <= '0;
                  phase <= PH_CHAR;
               end
            end
            S_FETCH: begin
               // Empty cells are stored as 0; send them as spaces.
               shreg    <= (read_data == 8'h00) ? 8'h20 : read_data;
               baud_cnt <= '0;
            end
            S_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_NEXT: begin
               baud_cnt <= '0;
               case (phase)
                  PH_CHAR: begin
                     if (col == COL_LAST) begin
                        shreg <= 8'h0D;
                        phase <= PH_CR;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
                  PH_CR: begin
                     shreg <= 8'h0A;
                     phase <= PH_LF;
                  end
                  default: begin
                     if (row != ROW_LAST) begin
                        row   <= row + 1'b1;
                        col   <= '0;
                        phase <= PH_CHAR;
                     end
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_START;
         S_START: if (baud_end) state_nxt = S_DATA;
         S_DATA:  if (baud_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
         S_STOP:  if (baud_end) state_nxt = S_NEXT;
         S_NEXT: begin
            case (phase)
               PH_CHAR: state_nxt = (col == COL_LAST) ? S_START : S_FETCH;
               PH_CR:   state_nxt = S_START;
               default: state_nxt = (row == ROW_LAST) ? S_DONE : S_FETCH;
            endcase
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode the state register directly, so an asynchronous reset
   // returns tx/busy/read_enable to idle without waiting for a clock.
   always_comb begin
      read_enable = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      tx          = 1'b1;
      case (state)
         S_IDLE:  busy = 1'b0;
         S_FETCH: read_enable = 1'b1;
         S_START: tx = 1'b0;
         S_DATA:  tx = shreg[bit_idx];
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_doc_uart_sender.sv
module tb_doc_uart_sender;

   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       send_a, send_b;
   logic       re_a, re_b;
   logic [8:0] addr_a, addr_b;
   logic [7:0] rd_a, rd_b;
   logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

   logic [7:0] doc [512];
   assign rd_a = doc[addr_a];
   assign rd_b = doc[addr_b];

   doc_uart_sender #(.CLKS_PER_BIT(CPB), .ROWS(2), .COLS(3)) dut_a (
      .clk(clk), .rst(rst), .send_data(send_a),
      .read_enable(re_a), .read_addr(addr_a), .read_data(rd_a),
      .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   doc_uart_sender #(.CLKS_PER_BIT(CPB), .ROWS(1), .COLS(1)) dut_b (
      .clk(clk), .rst(rst), .send_data(send_b),
      .read_enable(re_b), .read_addr(addr_b), .read_data(rd_b),
      .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bookkeeping sampled on the falling edge.
   logic [7:0] rx_a[$], rx_b[$];
   logic [8:0] aq_a[$], aq_b[$];
   int done_cnt_a = 0, done_cnt_b = 0;

   always @(negedge clk) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (re_a) aq_a.push_back(addr_a);
      if (re_b) aq_b.push_back(addr_b);
   end

   // UART receivers: detect the start bit, then sample each bit in its
   // first full cycle after the driving edge.
   initial forever begin
      logic [7:0] b;
      @(negedge clk);
      if (rst === 1'b0 && tx_a === 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_a;
         end
         repeat (CPB) @(negedge clk);
         rx_a.push_back(b);
      end
   end

   initial forever begin
      logic [7:0] b;
      @(negedge clk);
      if (rst === 1'b0 && tx_b === 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_b;
         end
         repeat (CPB) @(negedge clk);
         rx_b.push_back(b);
      end
   end

   typedef struct packed {
      logic [47:0] cells;  // cell 0 in the top byte
      logic [79:0] exp;    // expected byte 0 in the top byte
   } vec_t;

   vec_t vecs [3];
   logic [8:0] exp_addr [6];

   task automatic run_a();
      int cyc;
      @(posedge clk); #1 send_a = 1'b1;
      @(posedge clk); #1;
      check("busy_after_start", busy_a, 1'b1);
      check("fetch_re", re_a, 1'b1);
      check("fetch_addr0", addr_a, 9'h000);
      send_a = 1'b0;
      cyc = 0;
      while (!done_a && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_seen", done_a, 1'b1);
      @(posedge clk); #1;
      check("done_one_cycle", done_a, 1'b0);
      check("busy_after_done", busy_a, 1'b0);
      check("re_idle", re_a, 1'b0);
   endtask

   task automatic do_vector(input int v);
      int base;
      for (int i = 0; i < 6; i++) doc[exp_addr[i]] = vecs[v].cells[47 - 8*i -: 8];
      rx_a.delete();
      aq_a.delete();
      base = done_cnt_a;
      run_a();
      repeat (5) @(posedge clk);
      #1;
      check("rx_count", rx_a.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < rx_a.size()) check($sformatf("rx_byte%0d_v%0d", i, v), rx_a[i], vecs[v].exp[79 - 8*i -: 8]);
      check("addr_count", aq_a.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < aq_a.size()) check($sformatf("addr%0d_v%0d", i, v), aq_a[i], exp_addr[i]);
      check("done_count", done_cnt_a - base, 1);
   endtask

   initial begin
      int base, cyc;
      logic frame_bits [10];

      vecs[0] = '{cells: {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46},
                  exp:   {8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A}};
      vecs[1] = '{cells: {8'h00, 8'h7F, 8'h31, 8'h20, 8'hFF, 8'h01},
                  exp:   {8'h20, 8'h7F, 8'h31, 8'h0D, 8'h0A, 8'h20, 8'hFF, 8'h01, 8'h0D, 8'h0A}};
      vecs[2] = '{cells: {8'h55, 8'hAA, 8'h00, 8'h00, 8'h80, 8'h0D},
                  exp:   {8'h55, 8'hAA, 8'h20, 8'h0D, 8'h0A, 8'h20, 8'h80, 8'h0D, 8'h0D, 8'h0A}};
      exp_addr = '{9'h000, 9'h001, 9'h002, 9'h020, 9'h021, 9'h022};
      frame_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 512; i++) doc[i] = 8'h00;

      rst = 1'b1;
      send_a = 1'b0;
      send_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", tx_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_re", re_a, 1'b0);
      check("rst_addr", addr_a, 9'h000);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Table-driven full scans.
      for (int v = 0; v < 3; v++) do_vector(v);

      // Basic 1x1 frame, cycle-exact line check.
      doc[0] = 8'h41;
      rx_b.delete();
      aq_b.delete();
      base = done_cnt_b;
      @(posedge clk); #1 send_b = 1'b1;
      @(posedge clk); #1;
      check("b_fetch_re", re_b, 1'b1);
      check("b_fetch_addr", addr_b, 9'h000);
      check("b_tx_idle_in_fetch", tx_b, 1'b1);
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < CPB; j++) begin
            @(posedge clk); #1;
            check($sformatf("b_line_bit%0d_c%0d", i, j), tx_b, frame_bits[i]);
         end
      cyc = 0;
      while (!done_b && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b_done_latency", cyc, 84);
      send_b = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("b_rx_count", rx_b.size(), 3);
      if (rx_b.size() == 3) begin
         check("b_rx0", rx_b[0], 8'h41);
         check("b_rx1", rx_b[1], 8'h0D);
         check("b_rx2", rx_b[2], 8'h0A);
      end
      check("b_re_count", aq_b.size(), 1);
      if (aq_b.size() > 0) check("b_re_addr", aq_b[0], 9'h000);
      check("b_done_count", done_cnt_b - base, 1);

      // Retrigger: toggle mid-transfer and hold high past done.
      for (int i = 0; i < 6; i++) doc[exp_addr[i]] = vecs[0].cells[47 - 8*i -: 8];
      rx_a.delete();
      base = done_cnt_a;
      @(posedge clk); #1 send_a = 1'b1;
      repeat (100) @(posedge clk);
      #1 send_a = 1'b0;
      repeat (3) @(posedge clk);
      #1 send_a = 1'b1;
      cyc = 0;
      while (!done_a && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("retrig_done_seen", done_a, 1'b1);
      repeat (60) @(posedge clk);
      #1;
      check("retrig_one_done", done_cnt_a - base, 1);
      check("retrig_idle", busy_a, 1'b0);
      check("retrig_rx_count", rx_a.size(), 10);
      send_a = 1'b0;
      repeat (2) @(posedge clk);
      do_vector(0);
      check("retrig_second_done", done_cnt_a - base, 2);

      // Reset during data bit 3 of the first byte (0x41, bit3 = 0).
      base = done_cnt_a;
      @(posedge clk); #1 send_a = 1'b1;
      @(posedge clk); #1 send_a = 1'b0;
      repeat (17) @(posedge clk);
      #2;
      check("bit3_low_before_rst", tx_a, 1'b0);
      check("busy_before_rst", busy_a, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_tx", tx_a, 1'b1);
      check("async_rst_busy", busy_a, 1'b0);
      check("async_rst_re", re_a, 1'b0);
      check("async_rst_done", done_a, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("no_done_after_rst", done_cnt_a - base, 0);
      check("idle_after_rst", busy_a, 1'b0);
      do_vector(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
